morse_player: RTL and testbench
===============================

MORSE_PLAYER -- requirements
Module: morse_player

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 10_000_000, which is the clk cycles per Morse time unit; legal range is 1 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a request to play the current code.
REQ-005 SHALL have port code, input, 5 bits: the 5-symbol digit code; 0 means short (dot), 1 means long (dash); code[4] is played first.
REQ-006 SHALL have port abort, input, 1 bit: cancels playback in progress.
REQ-007 SHALL have port tone_out, output, 1 bit: 1 while a mark is sounding.
REQ-008 SHALL have port busy, output, 1 bit: 1 while playback is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when playback completes normally.
REQ-010 SHALL have port sym_idx, output, 3 bits: index of the current symbol, 0..4, where 0 is code[4].

Function
REQ-011 SHALL use states IDLE, MARK, GAP, TAIL; all outputs SHALL be registered.
REQ-012 In IDLE with start=1 and abort=0 at edge t, the block SHALL latch code and enter MARK at t+1 with sym_idx=0, tone_out=1, busy=1.
REQ-013 MARK SHALL last UNIT_CYCLES cycles for a 0 symbol and 3*UNIT_CYCLES cycles for a 1 symbol, with tone_out=1 throughout.
REQ-014 After MARK for sym_idx 0..3, the block SHALL enter GAP for UNIT_CYCLES cycles with tone_out=0, then enter MARK with sym_idx incremented.
REQ-015 After MARK for sym_idx=4, the block SHALL enter TAIL for 3*UNIT_CYCLES cycles with tone_out=0 (inter-character gap).
REQ-016 In the cycle after the last TAIL cycle, the block SHALL be in IDLE with done=1, busy=0, tone_out=0 and sym_idx=0; done SHALL be 0 in every other cycle.
REQ-017 Total busy duration SHALL be (sum of mark lengths) + 7*UNIT_CYCLES cycles; done SHALL occur at t+1+that duration.
REQ-018 start while busy=1 SHALL be ignored, and the latched code SHALL be unaffected by later changes on code.
REQ-019 start in the done cycle SHALL be accepted, giving back-to-back playback with no idle cycle beyond the done cycle.
REQ-020 abort=1 while busy=1 SHALL force IDLE at the next edge with tone_out=0, busy=0, sym_idx=0 and no done pulse.
REQ-021 abort SHALL have priority over start and over all timer expiries; abort=1 in IDLE SHALL be a no-op.
REQ-022 abort=1 together with start=1 in IDLE SHALL start nothing.
REQ-023 The duration counter SHALL be wide enough to hold 3*UNIT_CYCLES-1 without overflow and SHALL reload on every state transition.
REQ-024 With UNIT_CYCLES=1, a dot SHALL be exactly 1 cycle and a gap exactly 1 cycle, with no skipped or merged states.

Reset
REQ-025 With rst=0 at a clock edge, the block SHALL enter IDLE with tone_out=0, busy=0, done=0, sym_idx=0, the counter cleared and the latched code cleared, regardless of current state.
REQ-026 rst=0 SHALL override start and abort; the first start accepted after reset is one sampled at an edge where rst=1.
REQ-027 A reset during playback SHALL produce no done pulse.

Verification (UNIT_CYCLES=4, start accepted at edge t)
REQ-028 code=5'b00000 (digit 5) SHALL give tone_out=1 in t+1..t+4, 0 in t+5..t+8, and five 4-cycle marks in total; busy SHALL be high for 48 cycles; done=1 only at t+49.
REQ-029 code=5'b11111 (digit 0) SHALL give five 12-cycle marks separated by 4-cycle gaps; busy SHALL be high for 88 cycles; done at t+89.
REQ-030 code=5'b01111 (digit 1) SHALL give a 4-cycle mark then four 12-cycle marks; busy SHALL be high for 80 cycles; done at t+81; sym_idx SHALL step 0..4 at each mark start.
REQ-031 abort at t+10 during digit 0 SHALL give tone_out=0, busy=0 at t+11 and no done pulse; a new start at t+12 SHALL begin playback at t+13.
REQ-032 start pulsed and code changed while busy SHALL leave the timing of the original digit unchanged; start held high through the done cycle SHALL restart at done+1.
REQ-033 rst=0 asserted during GAP of digit 7 SHALL force all outputs to their reset values at the next edge with no done pulse, and start after release SHALL play normally.

Source files
------------

// File: rtl/morse_player.sv
// Morse digit player: plays a 5-symbol code (dot = 1 unit, dash = 3 units)
// with 1-unit gaps between symbols and a 3-unit inter-character tail.
module morse_player #(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] code,
  input  logic       abort,
  output logic       tone_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] sym_idx
);

  // The counter must hold the longest segment length minus one (a dash or
  // the tail, both 3 units); the max() keeps the width legal when that is 1.
  localparam int CW = (3 * UNIT_CYCLES > 2) ? $clog2(3 * UNIT_CYCLES) : 1;

  // Reload values are "length minus one" so a segment of N cycles counts N-1..0.
  localparam logic [CW-1:0] DOT_LEN  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LEN = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LEN  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] TAIL_LEN = CW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    TAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  // Latched code, shifted left as symbols are consumed; bit 4 is always the
  // symbol currently sounding and bit 3 the one that follows it.
  logic [4:0]    pattern;

  // Single sequencer: reset first, then abort (beats start and every timer
  // expiry), then the normal IDLE -> MARK -> GAP ... -> TAIL -> IDLE walk.
  // done defaults low so it can only ever be a one-cycle pulse.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      pattern  <= '0;
      tone_out <= 1'b0;
      busy     <= 1'b0;
      sym_idx  <= 3'd0;
    end else if (abort && state != IDLE) begin
      state    <= IDLE;
      count    <= '0;
      tone_out <= 1'b0;
      busy     <= 1'b0;
      sym_idx  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pattern  <= code;
            state    <= MARK;
            count    <= code[4] ? DASH_LEN : DOT_LEN;
            tone_out <= 1'b1;
            busy     <= 1'b1;
            sym_idx  <= 3'd0;
          end
        end
        MARK: begin
          if (count == '0) begin
            tone_out <= 1'b0;
            if (sym_idx == 3'd4) begin
              state <= TAIL;
              count <= TAIL_LEN;
            end else begin
              state <= GAP;
              count <= GAP_LEN;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        GAP: begin
          if (count == '0) begin
            state    <= MARK;
            tone_out <= 1'b1;
            sym_idx  <= sym_idx + 3'd1;
            pattern  <= {pattern[3:0], 1'b0};
            count    <= pattern[3] ? DASH_LEN : DOT_LEN;
          end else begin
            count <= count - CW'(1);
          end
        end
        TAIL: begin
          if (count == '0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sym_idx <= 3'd0;
            done    <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          tone_out <= 1'b0;
          busy     <= 1'b0;
          sym_idx  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: two instances (UNIT_CYCLES=4 and =1) share the
// stimulus; a timeline model computes expected outputs every cycle and
// directed scenarios pin timing with hand-computed literals.
module tb_morse_player;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [4:0] code;

  logic       tone0, busy0, done0;
  logic [2:0] sym0;
  logic       tone1, busy1, done1;
  logic [2:0] sym1;

  int checks = 0;
  int errors = 0;

  morse_player #(.UNIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .code(code), .abort(abort),
    .tone_out(tone0), .busy(busy0), .done(done0), .sym_idx(sym0)
  );

  morse_player #(.UNIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .code(code), .abort(abort),
    .tone_out(tone1), .busy(busy1), .done(done1), .sym_idx(sym1)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Total busy length of one playback: marks plus four gaps plus the tail
  function automatic int dur(input logic [4:0] c, input int u);
    int total = 7 * u;
    for (int j = 0; j < 5; j++) total += c[j] ? 3 * u : u;
    return total;
  endfunction

  // Expected tone and symbol index k cycles into a playback
  function automatic void exp_at(input logic [4:0] c, input int k, input int u,
                                 output logic t, output logic [2:0] s);
    int r = k;
    t = 1'b0;
    s = 3'd4;
    for (int i = 0; i < 5; i++) begin
      int len;
      len = c[4-i] ? 3 * u : u;
      if (r < len) begin
        t = 1'b1;
        s = 3'(i);
        return;
      end
      r -= len;
      if (i < 4) begin
        if (r < u) begin
          t = 1'b0;
          s = 3'(i);
          return;
        end
        r -= u;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [4:0] c);
    @(negedge clk);
    start = s;
    abort = a;
    code  = c;
  endtask

  // Model state per instance: index 0 is UNIT_CYCLES=4, index 1 is =1
  bit         m_act  [2];
  bit         m_done [2];
  logic [4:0] m_code [2];
  int         m_k    [2];

  // Model update: sample inputs at each rising edge like the DUT would
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        int u;
        u = (i == 0) ? 4 : 1;
        m_done[i] = 1'b0;
        if (!rst) begin
          m_act[i] = 1'b0;
        end else if (m_act[i]) begin
          if (abort) begin
            m_act[i] = 1'b0;
          end else begin
            m_k[i]++;
            if (m_k[i] == dur(m_code[i], u)) begin
              m_act[i]  = 1'b0;
              m_done[i] = 1'b1;
            end
          end
        end else if (start && !abort) begin
          m_act[i]  = 1'b1;
          m_code[i] = code;
          m_k[i]    = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic       et;
        logic [2:0] es;
        logic       eb;
        int         u;
        u = (i == 0) ? 4 : 1;
        if (m_act[i]) begin
          exp_at(m_code[i], m_k[i], u, et, es);
          eb = 1'b1;
        end else begin
          et = 1'b0;
          es = 3'd0;
          eb = 1'b0;
        end
        checkOutput($sformatf("u%0d tone_out", u), (i == 0) ? tone0 : tone1, et);
        checkOutput($sformatf("u%0d busy", u), (i == 0) ? busy0 : busy1, eb);
        checkOutput($sformatf("u%0d done", u), (i == 0) ? done0 : done1, m_done[i]);
        checkOutput($sformatf("u%0d sym_idx", u), (i == 0) ? sym0 : sym1, es);
      end
    end
  end

  // One playback on the UNIT_CYCLES=4 instance, measured from offset 1
  // (first cycle after the accepting edge); optionally disturbs start/code.
  task automatic play(input logic [4:0] c, input int exp_busy, input int exp_tone,
                      input bit disturb, input string name);
    int busy_n = 0;
    int tone_n = 0;
    int done_at = 0;
    int rises = 0;
    bit prev = 1'b0;
    applyStimulus(1'b1, 1'b0, c);
    @(negedge clk);
    start = 1'b0;
    for (int off = 1; off <= exp_busy + 10; off++) begin
      if (busy0) busy_n++;
      if (tone0) tone_n++;
      if (tone0 && !prev) begin
        checkOutput({name, " sym at mark start"}, sym0, rises);
        rises++;
      end
      prev = tone0;
      if (done0 && done_at == 0) done_at = off;
      if (disturb) begin
        start = (off >= 20 && off < 23);
        code  = c ^ 5'(off);
      end
      @(negedge clk);
    end
    code = c;
    checkOutput({name, " busy cycles"}, busy_n, exp_busy);
    checkOutput({name, " done offset"}, done_at, exp_busy + 1);
    checkOutput({name, " tone cycles"}, tone_n, exp_tone);
    checkOutput({name, " mark count"}, rises, 5);
  endtask

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    code  = 5'b00000;

    // Pin the model with hand-derived figures
    begin
      logic       t;
      logic [2:0] s;
      checkOutput("model dur digit5", dur(5'b00000, 4), 48);
      checkOutput("model dur digit0", dur(5'b11111, 4), 88);
      checkOutput("model dur digit1", dur(5'b01111, 4), 80);
      checkOutput("model dur digit5 u1", dur(5'b00000, 1), 12);
      exp_at(5'b00000, 4, 4, t, s);
      checkOutput("model digit5 k4 tone", t, 0);
      exp_at(5'b01111, 8, 4, t, s);
      checkOutput("model digit1 k8 sym", s, 1);
    end

    // Reset state, start ignored while rst is low
    start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy0, 0);
    checkOutput("reset tone", tone0, 0);
    checkOutput("reset sym", sym0, 0);
    checkOutput("reset done", done0, 0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // Abort alone and abort with start in IDLE start nothing
    applyStimulus(1'b0, 1'b1, 5'b11111);
    applyStimulus(1'b1, 1'b1, 5'b11111);
    applyStimulus(1'b0, 1'b0, 5'b11111);
    checkOutput("abort+start idle busy", busy0, 0);
    repeat (2) @(negedge clk);

    $display("[TB] digit 5, 1 and 0 playback");
    play(5'b00000, 48, 20, 1'b0, "digit5");
    play(5'b01111, 80, 52, 1'b0, "digit1");
    play(5'b11111, 88, 60, 1'b1, "digit0 disturbed");

    $display("[TB] start held through done");
    applyStimulus(1'b1, 1'b0, 5'b00000);
    for (int off = 1; off <= 50; off++) begin
      @(negedge clk);
      if (off == 49) checkOutput("held start done", done0, 1);
      if (off == 50) begin
        checkOutput("held start restart busy", busy0, 1);
        checkOutput("held start restart tone", tone0, 1);
        start = 1'b0;
      end
    end
    repeat (55) @(negedge clk);

    $display("[TB] abort during digit 0");
    begin
      int done_seen = 0;
      applyStimulus(1'b1, 1'b0, 5'b11111);
      for (int off = 1; off <= 14; off++) begin
        @(negedge clk);
        if (off == 1) start = 1'b0;
        if (off >= 11 && done0) done_seen++;
        if (off == 10) abort = 1'b1;
        if (off == 11) begin
          checkOutput("abort busy", busy0, 0);
          checkOutput("abort tone", tone0, 0);
          abort = 1'b0;
        end
        if (off == 12) start = 1'b1;
        if (off == 13) begin
          checkOutput("restart after abort busy", busy0, 1);
          checkOutput("restart after abort sym", sym0, 0);
          start = 1'b0;
        end
      end
      checkOutput("abort no done", done_seen, 0);
      repeat (95) @(negedge clk);
    end

    $display("[TB] reset during gap of digit 7");
    begin
      int done_seen = 0;
      applyStimulus(1'b1, 1'b0, 5'b11000);
      for (int off = 1; off <= 40; off++) begin
        @(negedge clk);
        if (off == 1) start = 1'b0;
        if (off >= 15 && done0) done_seen++;
        if (off == 14) rst = 1'b0;
        if (off == 15) begin
          checkOutput("gap reset busy", busy0, 0);
          checkOutput("gap reset tone", tone0, 0);
          checkOutput("gap reset sym", sym0, 0);
        end
        if (off == 16) rst = 1'b1;
      end
      checkOutput("gap reset no done", done_seen, 0);
    end
    play(5'b00000, 48, 20, 1'b0, "post-reset digit5");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
